// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants for the uart transmit arbiter: FSM encodings, tag prefix and index width helper.
package uart_tx_arbiter_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_REQ       = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;

  localparam logic [7:0] TAG_BASE = 8'hA0;

  typedef logic [7:0] byte_t;

  function automatic int arb_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: first set request at or after rr_ptr, wrapping.
module rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = arb_idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               any,
  output logic [IDX_W-1:0]   idx
);

  // Scan from the farthest offset down so the nearest hit to rr_ptr wins.
  always_comb begin
    int pos_i;
    logic [IDX_W-1:0] pos_s;
    pos_i = 0;
    pos_s = {IDX_W{1'b0}};
    any   = 1'b0;
    idx   = {IDX_W{1'b0}};
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos_i = (int'(rr_ptr) + k) % NUM_REQ;
      pos_s = IDX_W'(pos_i);
      any   = any | req[pos_s];
      idx   = req[pos_s] ? pos_s : idx;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart transmitter; latches a whole message per grant, sends MS byte first.
// Optional feature macro UART_ARB_TAG_EN: prefix each message with tag byte TAG_BASE | grant index.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MSG_BYTES = 4,
  localparam int IDX_W = arb_idx_w(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*MSG_BYTES*8-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ack,
  output logic [IDX_W-1:0]               grant_idx,
  output logic                           arb_busy,
  output logic [7:0]                     tx_byte,
  output logic                           tx_req,
  input  logic                           tx_busy
);

  localparam int MSG_W = MSG_BYTES * 8;
`ifdef UART_ARB_TAG_EN
  localparam int SH_BYTES = MSG_BYTES + 1;
`else
  localparam int SH_BYTES = MSG_BYTES;
`endif
  localparam int SH_W  = SH_BYTES * 8;
  localparam int CNT_W = $clog2(SH_BYTES + 1);

  logic [1:0]         state_r;
  logic [SH_W-1:0]    shift_r;
  logic [CNT_W-1:0]   byte_cnt_r;
  logic [IDX_W-1:0]   rr_ptr_r;
  logic               idle_seen_r;
  logic [NUM_REQ-1:0] req_ack_r;
  logic [IDX_W-1:0]   grant_idx_r;
  logic               arb_busy_r;
  logic [7:0]         tx_byte_r;
  logic               tx_req_r;

  logic               pick_any_s;
  logic [IDX_W-1:0]   pick_idx_s;
  logic [MSG_W-1:0]   slice_s;
  logic [SH_W-1:0]    load_s;
  logic [SH_W-1:0]    shift_next_s;
  logic [IDX_W-1:0]   next_ptr_s;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr_r),
    .any    (pick_any_s),
    .idx    (pick_idx_s)
  );

  // Select the granted slice and form the shift-register load value.
  always_comb begin
    slice_s = {MSG_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      slice_s = (pick_idx_s == IDX_W'(i)) ? req_data[i*MSG_W +: MSG_W] : slice_s;
    end
`ifdef UART_ARB_TAG_EN
    load_s = {TAG_BASE | 8'(pick_idx_s), slice_s};
`else
    load_s = slice_s;
`endif
    shift_next_s = shift_r << 4'd8;
    if (grant_idx_r == IDX_W'(NUM_REQ - 1)) begin
      next_ptr_s = {IDX_W{1'b0}};
    end else begin
      next_ptr_s = grant_idx_r + IDX_W'(1);
    end
  end

  // Arbitration FSM with byte shifter and uart handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      shift_r     <= {SH_W{1'b0}};
      byte_cnt_r  <= {CNT_W{1'b0}};
      rr_ptr_r    <= {IDX_W{1'b0}};
      idle_seen_r <= 1'b0;
      req_ack_r   <= {NUM_REQ{1'b0}};
      grant_idx_r <= {IDX_W{1'b0}};
      arb_busy_r  <= 1'b0;
      tx_byte_r   <= 8'h00;
      tx_req_r    <= 1'b0;
    end else begin
      req_ack_r <= {NUM_REQ{1'b0}};
      case (state_r)
        ST_IDLE: begin
          if (pick_any_s) begin
            shift_r     <= load_s;
            byte_cnt_r  <= CNT_W'(SH_BYTES);
            req_ack_r   <= NUM_REQ'(1) << pick_idx_s;
            grant_idx_r <= pick_idx_s;
            arb_busy_r  <= 1'b1;
            tx_byte_r   <= load_s[SH_W-1 -: 8];
            tx_req_r    <= 1'b1;
            idle_seen_r <= 1'b0;
            state_r     <= ST_REQ;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_REQ: begin
          // A busy already present on entry belongs to someone else; wait for it to clear first.
          if (tx_busy && idle_seen_r) begin
            tx_req_r <= 1'b0;
            state_r  <= ST_WAIT_DONE;
          end else begin
            tx_req_r    <= 1'b1;
            idle_seen_r <= idle_seen_r | ~tx_busy;
          end
        end
        ST_WAIT_DONE: begin
          if (!tx_busy) begin
            if (byte_cnt_r > CNT_W'(1)) begin
              shift_r     <= shift_next_s;
              byte_cnt_r  <= byte_cnt_r - CNT_W'(1);
              tx_byte_r   <= shift_next_s[SH_W-1 -: 8];
              tx_req_r    <= 1'b1;
              idle_seen_r <= 1'b0;
              state_r     <= ST_REQ;
            end else begin
              rr_ptr_r   <= next_ptr_s;
              arb_busy_r <= 1'b0;
              state_r    <= ST_IDLE;
            end
          end else begin
            state_r <= ST_WAIT_DONE;
          end
        end
        default: begin
          tx_req_r   <= 1'b0;
          arb_busy_r <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ack   = req_ack_r;
  assign grant_idx = grant_idx_r;
  assign arb_busy  = arb_busy_r;
  assign tx_byte   = tx_byte_r;
  assign tx_req    = tx_req_r;

endmodule
